// File: rtl/aq_dtu_trig_pulse_gen.sv
// aq_dtu_trig_pulse_gen: paces queued DTU trigger events into spaced single-cycle pulses for the CDC synchroniser.
// Defining AQ_DTU_TRIG_COALESCE_EN collapses pending events into a single flag and disables overflow reporting.
module aq_dtu_trig_pulse_gen #(
    parameter int CNT_WIDTH  = 4,
    parameter int GAP_CYCLES = 16,
    parameter int GAP_WIDTH  = 5
) (
    input  logic                 src_clk,
    input  logic                 src_rst,
    input  logic                 trig_evt,
    input  logic                 trig_en,
    input  logic                 ovf_clr,
    output logic                 src_pulse,
    output logic [CNT_WIDTH-1:0] pend_cnt,
    output logic                 evt_ovf,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
    state_t               state;
    logic [GAP_WIDTH-1:0] gap_cnt;
    logic                 pend_any;
    assign src_pulse = state == PULSE;
    assign busy      = state != IDLE;
    always_ff @(posedge src_clk)
        if (src_rst) begin
            state   <= IDLE;
            gap_cnt <= '0;
        end else
            case (state)
                IDLE:  state <= pend_any ? PULSE : IDLE;
                PULSE: begin
                    state   <= GAP;
                    gap_cnt <= GAP_WIDTH'(GAP_CYCLES - 1);
                end
                GAP:
                    if (gap_cnt == '0) state <= (pend_any & trig_en) ? PULSE : IDLE;
                    else gap_cnt <= gap_cnt - 1'b1;
                default: state <= IDLE;
            endcase
`ifdef AQ_DTU_TRIG_COALESCE_EN
    logic pend_flag;
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign pend_any       = pend_flag;
    assign pend_cnt       = {{(CNT_WIDTH-1){1'b0}}, pend_flag};
    assign evt_ovf        = 1'b0;
    // an event landing in the pulse cycle re-arms the flag rather than being absorbed
    always_ff @(posedge src_clk)
        if (src_rst) pend_flag <= 1'b0;
        else pend_flag <= trig_en & (trig_evt | (pend_flag & ~src_pulse));
`else
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    logic full, inc, dec, ovf_set;
    assign pend_any = pend_cnt != '0;
    assign full     = pend_cnt == CNT_MAX;
    assign inc      = trig_evt & trig_en & ~full;
    assign dec      = src_pulse & pend_any;
    assign ovf_set  = trig_evt & trig_en & full & ~src_pulse;
    always_ff @(posedge src_clk)
        if (src_rst) begin
            pend_cnt <= '0;
            evt_ovf  <= 1'b0;
        end else begin
            pend_cnt <= trig_en ? pend_cnt + CNT_WIDTH'(inc) - CNT_WIDTH'(dec) : '0;
            evt_ovf  <= ovf_set | (evt_ovf & ~ovf_clr);
        end
`endif
endmodule

// File: tb/tb_aq_dtu_trig_pulse_gen.sv
// tb_aq_dtu_trig_pulse_gen: directed stimulus with a cycle-timing reference model checked every cycle.
module tb_aq_dtu_trig_pulse_gen;
    localparam int CW = 4, GAP = 16, GW = 5, MAXC = (1 << CW) - 1;
    logic src_clk = 1'b0, src_rst = 1'b1, trig_evt = 1'b1, trig_en = 1'b1, ovf_clr = 1'b0;
    logic src_pulse, evt_ovf, busy;
    logic [CW-1:0] pend_cnt;
    int tests = 0, fails = 0;
    int cyc = 0, m_pend = 0, m_last = -1000;
    bit m_pulse = 1'b0, m_ovf = 1'b0, chk_on = 1'b0, nxt_m;
    int pq[$];
    int maxp;

    aq_dtu_trig_pulse_gen #(.CNT_WIDTH(CW), .GAP_CYCLES(GAP), .GAP_WIDTH(GW)) dut (
        .src_clk(src_clk), .src_rst(src_rst), .trig_evt(trig_evt), .trig_en(trig_en),
        .ovf_clr(ovf_clr), .src_pulse(src_pulse), .pend_cnt(pend_cnt), .evt_ovf(evt_ovf), .busy(busy)
    );

    always #5 src_clk = ~src_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge src_clk);
    endtask

    // pulse at cycle c+1 when work is pending and either the gap just ran out with trig_en high, or the block is idle
    always @(posedge src_clk) begin
        if (src_rst) begin
            m_pend = 0; m_ovf = 0; m_pulse = 0; m_last = -1000;
        end else begin
            nxt_m = m_pend > 0 && ((cyc == m_last + GAP && trig_en) || cyc > m_last + GAP);
`ifdef AQ_DTU_TRIG_COALESCE_EN
            m_pend = (trig_en && (trig_evt || (m_pend > 0 && !m_pulse))) ? 1 : 0;
`else
            if (trig_evt && trig_en && m_pend == MAXC && !m_pulse) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
            m_pend = !trig_en ? 0 : m_pend + ((trig_evt && m_pend < MAXC) ? 1 : 0) - ((m_pulse && m_pend > 0) ? 1 : 0);
`endif
            m_pulse = nxt_m;
            if (nxt_m) m_last = cyc + 1;
        end
        cyc++;
        chk_on = 1'b1;
    end

    always @(negedge src_clk)
        if (chk_on) begin
            chk("model_src_pulse", 32'(src_pulse), 32'(m_pulse));
            chk("model_busy", 32'(busy), 32'(cyc >= m_last && cyc <= m_last + GAP));
            chk("model_pend_cnt", 32'(pend_cnt), 32'(m_pend));
            chk("model_evt_ovf", 32'(evt_ovf), 32'(m_ovf));
        end

    initial begin
        tick;
        chk("rst_pulse", 32'(src_pulse), 0); chk("rst_busy", 32'(busy), 0);
        chk("rst_pend", 32'(pend_cnt), 0); chk("rst_ovf", 32'(evt_ovf), 0);
        tick;
        chk("rst2_pulse", 32'(src_pulse), 0); chk("rst2_pend", 32'(pend_cnt), 0);
        src_rst = 1'b0; trig_evt = 1'b0;
        tick;
        chk("rel_pulse", 32'(src_pulse), 0); chk("rel_busy", 32'(busy), 0);
        chk("rel_pend", 32'(pend_cnt), 0); chk("rel_ovf", 32'(evt_ovf), 0);
        repeat (3) tick;
        trig_evt = 1'b1; tick; trig_evt = 1'b0;
        chk("single_pend_e1", 32'(pend_cnt), 1); chk("single_pulse_e1", 32'(src_pulse), 0);
        tick;
        chk("single_pulse_e2", 32'(src_pulse), 1); chk("single_busy_e2", 32'(busy), 1);
        chk("single_pend_e2", 32'(pend_cnt), 1);
        tick;
        chk("single_pulse_e3", 32'(src_pulse), 0); chk("single_pend_e3", 32'(pend_cnt), 0);
        repeat (15) tick;
        chk("single_busy_e18", 32'(busy), 1);
        tick;
        chk("single_busy_e19", 32'(busy), 0);
        repeat (3) tick;
`ifdef AQ_DTU_TRIG_COALESCE_EN
        pq.delete();
        for (int i = 0; i < 60; i++) begin
            trig_evt = i < 5;
            if (src_pulse) pq.push_back(i);
            if (i == 40) chk("coal_ovf", 32'(evt_ovf), 0);
            tick;
        end
        chk("coal_npulse", 32'(pq.size()), 2);
        if (pq.size() == 2) begin
            chk("coal_p0", 32'(pq[0]), 2); chk("coal_p1", 32'(pq[1]), 19);
        end
`else
        pq.delete(); maxp = 0;
        for (int i = 0; i < 54; i++) begin
            trig_evt = i < 3;
            if (src_pulse) pq.push_back(i);
            if (int'(pend_cnt) > maxp) maxp = int'(pend_cnt);
            if (i == 52) chk("burst_busy_e52", 32'(busy), 1);
            if (i == 53) begin
                chk("burst_busy_e53", 32'(busy), 0); chk("burst_pend_e53", 32'(pend_cnt), 0);
            end
            tick;
        end
        chk("burst_maxpend", 32'(maxp), 2);
        chk("burst_npulse", 32'(pq.size()), 3);
        if (pq.size() == 3) begin
            chk("burst_p0", 32'(pq[0]), 2); chk("burst_p1", 32'(pq[1]), 19); chk("burst_p2", 32'(pq[2]), 36);
        end
        pq.delete();
        for (int i = 0; i < 40; i++) begin
            trig_evt = 1'b1;
            if (src_pulse) pq.push_back(i);
            tick;
        end
        trig_evt = 1'b0;
        chk("ovf_pend_sat", 32'(pend_cnt), 15); chk("ovf_set", 32'(evt_ovf), 1);
        chk("ovf_hold_pulses", 32'(pq.size()), 3);
        ovf_clr = 1'b1; tick; ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(evt_ovf), 0);
        pq.delete();
        for (int i = 0; i < 275; i++) begin
            if (src_pulse) pq.push_back(i);
            tick;
        end
        chk("ovf_drain_pulses", 32'(pq.size()), 15);
        chk("ovf_drain_pend", 32'(pend_cnt), 0); chk("ovf_drain_busy", 32'(busy), 0);
`endif
        pq.delete();
        for (int i = 0; i < 45; i++) begin
            trig_evt = i < 3 || i == 10;
            trig_en  = !(i >= 7 && i < 40);
            if (src_pulse) pq.push_back(i);
            if (i == 8) chk("dis_pend_e8", 32'(pend_cnt), 0);
            if (i == 12) chk("dis_ovf_e12", 32'(evt_ovf), 0);
            if (i == 18) chk("dis_busy_e18", 32'(busy), 1);
            if (i == 19) chk("dis_busy_e19", 32'(busy), 0);
            tick;
        end
        chk("dis_npulse", 32'(pq.size()), 1);
        trig_en = 1'b1;
        pq.delete();
        for (int i = 0; i < 30; i++) begin
            trig_evt = i < 3;
            src_rst  = i == 5;
            if (src_pulse) pq.push_back(i);
            if (i == 6) begin
                chk("mrst_pend", 32'(pend_cnt), 0); chk("mrst_busy", 32'(busy), 0);
                chk("mrst_pulse", 32'(src_pulse), 0);
            end
            tick;
        end
        chk("mrst_npulse", 32'(pq.size()), 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
